// File: rtl/multicycle_control_unit_if.sv
// Instruction fields, flags and datapath controls exchanged
// between the multicycle controller and its datapath.
interface multicycle_control_unit_if;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       MemReady;
   logic       IRWrite;
   logic       AdrSrc;
   logic       ALUSrcA;
   logic       PCWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic [1:0] ALUControl;
   logic [3:0] FlagsReg;
   logic [3:0] State;

   modport master (
      output Cond, Op, Funct, Rd, ALUFlags, MemReady,
      input  IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite,
      input  MemWrite, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
      input  ALUControl, FlagsReg, State
   );

   modport slave (
      input  Cond, Op, Funct, Rd, ALUFlags, MemReady,
      output IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite,
      output MemWrite, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
      output ALUControl, FlagsReg, State
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset control FSM with NZCV flag register.
// Define MULTICYCLE_CTRL_MEMWAIT_EN to stall on MemReady=0.
module multicycle_control_unit (
   input logic                        Clk,
   input logic                        Reset,
   multicycle_control_unit_if.slave   bus
);
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } state_t;

   state_t     state;
   state_t     next;
   logic       rst_seen;
   logic [3:0] flags;
   logic       cond_ex;
   logic       is_cmp;
   logic       upd_cv;
   logic [1:0] dp_alu;
   logic       wr_ok;
   logic       ir, pc, rw, mw;
   logic       adr_src, src_a;
   logic [1:0] src_b, res_src, reg_src, alu_ctl;
   logic       rd_unused;

   logic n, z, c, v;
   assign n = flags[3];
   assign z = flags[2];
   assign c = flags[1];
   assign v = flags[0];

   // Rd=15 gets no special treatment in this controller
   assign rd_unused = ^bus.Rd;

   assign is_cmp = (bus.Funct[4:1] == 4'b1010);
   assign upd_cv = (bus.Funct[4:1] == 4'b0100) ||
                   (bus.Funct[4:1] == 4'b0010) || is_cmp;

   // Write enables stay low while reset is sampled and one cycle after
   assign wr_ok = Reset & ~rst_seen;

   // Condition check against the registered flags
   always_comb begin
      cond_ex = 1'b0;
      case (bus.Cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~c | z;
         4'b1010: cond_ex = (n == v);
         4'b1011: cond_ex = (n != v);
         4'b1100: cond_ex = ~z & (n == v);
         4'b1101: cond_ex = z | (n != v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Data-processing ALU operation select
   always_comb begin
      dp_alu = 2'b00;
      case (bus.Funct[4:1])
         4'b0100: dp_alu = 2'b00;
         4'b0010: dp_alu = 2'b01;
         4'b1010: dp_alu = 2'b01;
         4'b0000: dp_alu = 2'b10;
         4'b1100: dp_alu = 2'b11;
         default: dp_alu = 2'b00;
      endcase
   end

   // Next-state and per-state control outputs
   always_comb begin
      next    = FETCH;
      ir      = 1'b0;
      pc      = 1'b0;
      rw      = 1'b0;
      mw      = 1'b0;
      adr_src = 1'b0;
      src_a   = 1'b0;
      src_b   = 2'b00;
      res_src = 2'b00;
      reg_src = 2'b00;
      alu_ctl = 2'b00;
      case (state)
         FETCH: begin
            src_a   = 1'b1;
            src_b   = 2'b10;
            res_src = 2'b10;
            ir      = 1'b1;
            pc      = 1'b1;
            next    = DECODE;
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
            if (!bus.MemReady) begin
               ir   = 1'b0;
               pc   = 1'b0;
               next = FETCH;
            end
`endif
            // first cycle out of reset does not fetch
            if (rst_seen) begin
               ir   = 1'b0;
               pc   = 1'b0;
               next = FETCH;
            end
         end
         DECODE: begin
            src_a      = 1'b1;
            src_b      = 2'b10;
            res_src    = 2'b10;
            reg_src[0] = (bus.Op == 2'b10);
            reg_src[1] = (bus.Op == 2'b01) & ~bus.Funct[0];
            if (cond_ex) begin
               case (bus.Op)
                  2'b01:   next = MEMADR;
                  2'b10:   next = BRANCH;
                  2'b00:   next = bus.Funct[5] ? EXECUTEI
                                               : EXECUTER;
                  default: next = FETCH;
               endcase
            end
         end
         MEMADR: begin
            next = bus.Funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            adr_src = 1'b1;
            next    = MEMWB;
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
            if (!bus.MemReady) next = MEMRD;
`endif
         end
         MEMWB: begin
            rw      = 1'b1;
            res_src = 2'b01;
         end
         MEMWR: begin
            adr_src = 1'b1;
            mw      = 1'b1;
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
            if (!bus.MemReady) next = MEMWR;
`endif
         end
         EXECUTER, EXECUTEI: begin
            alu_ctl = dp_alu;
            next    = ALUWB;
         end
         ALUWB: begin
            rw = ~is_cmp;
         end
         BRANCH: begin
            pc      = 1'b1;
            src_b   = 2'b01;
            res_src = 2'b10;
         end
         default: next = FETCH;
      endcase
   end

   // Remember that reset was sampled on the previous edge
   always_ff @(posedge Clk) begin
      rst_seen <= ~Reset;
   end

   // State register
   always_ff @(posedge Clk) begin
      if (!Reset) state <= FETCH;
      else        state <= next;
   end

   // Flag capture when leaving an S-suffixed execute
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         flags <= 4'b0000;
      end else if ((state == EXECUTER || state == EXECUTEI)
                   && bus.Funct[0]) begin
         flags[3:2] <= bus.ALUFlags[3:2];
         if (upd_cv) flags[1:0] <= bus.ALUFlags[1:0];
      end
   end

   assign bus.IRWrite    = ir & wr_ok;
   assign bus.PCWrite    = pc & wr_ok;
   assign bus.RegWrite   = rw & wr_ok;
   assign bus.MemWrite   = mw & wr_ok;
   assign bus.AdrSrc     = adr_src;
   assign bus.ALUSrcA    = src_a;
   assign bus.ALUSrcB    = src_b;
   assign bus.ResultSrc  = res_src;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = reg_src;
   assign bus.ALUControl = alu_ctl;
   assign bus.FlagsReg   = flags;
   assign bus.State      = state;
endmodule
